// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its RAM.
package mem_pkg;

  localparam int WAIT_W = 4;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OP_RD, OP_FETCH, OP_WR} op_t;

  // fetch only qualifies reads; a write ignores it
  function automatic op_t decode_op(input logic wr, input logic fe);
    if (wr) return OP_WR;
    return fe ? OP_FETCH : OP_RD;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with write enable and registered read data.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset; RAM macros have none and contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we && (int'(addr) < DEPTH)) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: wait-stated read/fetch/write access to an owned RAM.
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag accesses with mar_q >= DEPTH.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic              fetch,
  input  logic [15:0]       mar_q,
  input  logic [15:0]       mdr_q,
  output logic [WORD_W-1:0] mmd_out,
  output logic [WORD_W-1:0] mis_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state;
  op_t                 op;
  logic [WAIT_W-1:0]   cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   data_q;
  logic                oob_q;
  logic                rsp_mmd;
  logic                rsp_mis;
  logic                commit;
  logic                ram_we;
  logic                ram_re;
  logic                oob_in;
  logic [WORD_W-1:0]   ram_rdata;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_in = (int'(mar_q) >= DEPTH);
`else
  assign oob_in = 1'b0;
`endif

  // The last ACCESS edge is the one that touches the RAM
  assign commit = (state == ACCESS) && (cnt == '0);
  assign ram_we = commit && (op == OP_WR) && !oob_q;
  assign ram_re = commit && (op != OP_WR);

  mem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  // The RAM read register is the data flop; the strobe flags zero both buses outside RESP.
  assign mmd_out = rsp_mmd ? ram_rdata : '0;
  assign mis_out = rsp_mis ? ram_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= IDLE;
      op      <= OP_RD;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      oob_q   <= 1'b0;
      rsp_mmd <= 1'b0;
      rsp_mis <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      rsp_mmd <= 1'b0;
      rsp_mis <= 1'b0;
      case (state)
        IDLE: begin
          if (req_rd ^ req_wr) begin
            state  <= ACCESS;
            busy   <= 1'b1;
            cnt    <= WAIT_W'(WAIT_CYCLES);
            op     <= decode_op(req_wr, fetch);
            addr_q <= mar_q[ADDR_W-1:0];
            data_q <= mdr_q;
            oob_q  <= oob_in;
          end else if (req_rd && req_wr) begin
            err <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state   <= RESP;
            done    <= 1'b1;
            err     <= oob_q;
            rsp_mmd <= (op == OP_RD) && !oob_q;
            rsp_mis <= (op == OP_FETCH) && !oob_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int W = 1;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam int DEPTH_T = 3072;
  localparam bit BOUNDS  = 1'b1;
`else
  localparam int DEPTH_T = 4096;
  localparam bit BOUNDS  = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        req_rd = 1'b0, req_wr = 1'b0, fetch = 1'b0;
  logic [15:0] mar_q = '0, mdr_q = '0;
  logic [15:0] mmd_out, mis_out;
  logic        busy, done, err;

  logic        f_req_rd = 1'b0, f_req_wr = 1'b0, f_fetch = 1'b0;
  logic [15:0] f_mar_q = '0, f_mdr_q = '0;
  logic [15:0] f_mmd_out, f_mis_out;
  logic        f_busy, f_done, f_err;

  always #5 CLK = ~CLK;

  mem_responder #(.ADDR_W(12), .DEPTH(DEPTH_T), .WAIT_CYCLES(W)) u_dut (
    .CLK(CLK), .CLR(CLR), .req_rd(req_rd), .req_wr(req_wr), .fetch(fetch),
    .mar_q(mar_q), .mdr_q(mdr_q), .mmd_out(mmd_out), .mis_out(mis_out),
    .busy(busy), .done(done), .err(err)
  );

  mem_responder #(.ADDR_W(12), .DEPTH(DEPTH_T), .WAIT_CYCLES(0)) u_fast (
    .CLK(CLK), .CLR(CLR), .req_rd(f_req_rd), .req_wr(f_req_wr), .fetch(f_fetch),
    .mar_q(f_mar_q), .mdr_q(f_mdr_q), .mmd_out(f_mmd_out), .mis_out(f_mis_out),
    .busy(f_busy), .done(f_done), .err(f_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference RAM, indexed by the wrapped word address
  logic [15:0] model [int];

  function automatic bit is_oob(input logic [15:0] a);
    return BOUNDS && (int'(a) >= DEPTH_T);
  endfunction

  // One full transaction on u_dut; entered and left on a falling edge.
  // noise: 0 quiet, 1 random requests while busy, 2 a write to 0x005 while busy.
  task automatic access(input bit wr, input bit fe, input logic [15:0] addr,
                        input logic [15:0] wdata, input int noise);
    int          idx;
    bit          oob;
    bit          known;
    logic [15:0] exp_rd;
    idx    = int'(addr[11:0]);
    oob    = is_oob(addr);
    known  = model.exists(idx);
    exp_rd = (oob || !known) ? 16'h0 : model[idx];
    req_rd = !wr; req_wr = wr; fetch = fe; mar_q = addr; mdr_q = wdata;
    @(posedge CLK); #1;
    req_rd = 1'b0; req_wr = 1'b0;
    fetch = 1'($urandom); mar_q = 16'($urandom); mdr_q = 16'($urandom);
    if (noise == 1) begin
      req_rd = 1'($urandom); req_wr = 1'($urandom);
    end else if (noise == 2) begin
      req_wr = 1'b1; mar_q = 16'h0005; mdr_q = 16'hDEAD;
    end
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge CLK); @(negedge CLK);
      check("busy_in_access", busy, 1);
      if (k <= W) check("done_early", done, 0);
    end
    check("done_strobe", done, 1);
    check("err_with_done", err, oob);
    if (wr) begin
      check("wr_mmd_zero", mmd_out, 0);
      check("wr_mis_zero", mis_out, 0);
    end else if (known || oob) begin
      check("rd_mmd", mmd_out, fe ? 16'h0 : exp_rd);
      check("rd_mis", mis_out, fe ? exp_rd : 16'h0);
    end
    @(posedge CLK); @(negedge CLK);
    req_rd = 1'b0; req_wr = 1'b0;
    check("done_single", done, 0);
    check("busy_released", busy, 0);
    check("err_cleared", err, 0);
    check("mmd_idle_zero", mmd_out, 0);
    check("mis_idle_zero", mis_out, 0);
    if (wr && !oob) model[idx] = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cycles;
    int          last;
    int          i;
    logic [15:0] a;

    repeat (3) @(negedge CLK);
    check("rst_mmd", mmd_out, 0);
    check("rst_mis", mis_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    CLR = 1'b1;
    @(negedge CLK);

    access(1, 0, 16'h0010, 16'h1111, 0);
    access(1, 0, 16'h0000, 16'h5555, 0);
    for (int j = 0; j < 16; j++) access(1, 0, 16'h0020 + 16'(j), 16'($urandom), 0);

    // Write then read back through each bus
    access(1, 1, 16'h0005, 16'h1234, 0);
    access(0, 0, 16'h0005, 16'h0, 0);
    access(0, 1, 16'h0005, 16'h0, 0);

    // Reset one edge before the write would commit
    req_wr = 1'b1; mar_q = 16'h0010; mdr_q = 16'hBEEF;
    @(posedge CLK); #1;
    req_wr = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("pre_rst_busy", busy, 1);
    CLR = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_err", err, 0);
    check("async_rst_mmd", mmd_out, 0);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    access(0, 0, 16'h0010, 16'h0, 0);

    // Conflicting request in IDLE
    req_rd = 1'b1; req_wr = 1'b1; mar_q = 16'h0005; mdr_q = 16'hFFFF;
    @(posedge CLK); @(negedge CLK);
    check("conflict_err", err, 1);
    check("conflict_busy", busy, 0);
    check("conflict_done", done, 0);
    req_rd = 1'b0; req_wr = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("conflict_err_once", err, 0);
    check("conflict_still_idle", busy, 0);
    access(0, 0, 16'h0005, 16'h0, 0);

    // A write presented while busy must be dropped
    access(0, 0, 16'h0021, 16'h0, 2);
    access(0, 0, 16'h0005, 16'h0, 0);

    // Address bounds / wrap
`ifdef MEM_BOUNDS_CHECK_EN
    access(1, 0, 16'h0C00, 16'hAAAA, 0);
    access(0, 0, 16'h0000, 16'h0, 0);
    access(0, 0, 16'h0C00, 16'h0, 0);
`else
    access(1, 0, 16'h1C00, 16'hAAAA, 0);
    access(0, 0, 16'h0C00, 16'h0, 0);
    access(0, 0, 16'h0000, 16'h0, 0);
`endif

    // Randomized traffic with ignored requests while busy
    for (int n = 0; n < 40; n++) begin
      a = {4'($urandom), 12'h020 | 12'($urandom_range(0, 15))};
      access($urandom_range(0, 2) == 0, 1'($urandom), a, 16'($urandom), 1);
    end

    // Zero-wait back-to-back writes then reads on the second instance
    i = 0; cycles = 0; last = 0;
    f_req_wr = 1'b1; f_mar_q = 16'h0; f_mdr_q = 16'h1000;
    while (i < 4 && cycles < 100) begin
      @(posedge CLK); @(negedge CLK);
      cycles++;
      if (f_done) begin
        if (i == 0) check("b2b_wr_first", cycles, 2);
        else check("b2b_wr_gap", cycles - last, 3);
        last = cycles; i++;
        f_mar_q = 16'(i); f_mdr_q = 16'h1000 + 16'(i);
      end
    end
    f_req_wr = 1'b0;
    check("b2b_wr_count", i, 4);
    @(negedge CLK); @(negedge CLK);

    i = 0; cycles = 0; last = 0;
    f_req_rd = 1'b1; f_fetch = 1'b0; f_mar_q = 16'h0;
    while (i < 4 && cycles < 100) begin
      @(posedge CLK); @(negedge CLK);
      cycles++;
      if (f_done) begin
        if (i == 0) check("b2b_rd_first", cycles, 2);
        else check("b2b_rd_gap", cycles - last, 3);
        check("b2b_rd_data", f_mmd_out, 16'h1000 + 16'(i));
        check("b2b_rd_mis", f_mis_out, 0);
        last = cycles; i++;
        f_mar_q = 16'(i);
      end else begin
        check("b2b_rd_idle_bus", f_mmd_out, 0);
      end
    end
    f_req_rd = 1'b0;
    check("b2b_rd_count", i, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
